// File: rtl/i2c_led_if.sv
// Command-side interface of the I2C LED write engine: one command
// (address + data byte) per valid/ready handshake, plus completion status.
interface i2c_led_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic       ack_error;

  // Local controller issuing commands
  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, ack_error
  );

  // Write engine serving commands
  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, busy, done, ack_error
  );
endinterface

// File: rtl/i2c_led_master.sv
// Single-master I2C write engine: START, addr+W, ACK, data, ACK, STOP.
// Each bit is four quarters of CLK_DIV clocks. SCL and the SDA pull-down
// enable are registered, and are computed from next-state values so that
// they line up exactly with the quarter boundaries.
module i2c_led_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  i2c_led_if.slave    cmd,
  output logic        scl,
  inout  wire         sda,
  output logic [3:0]  debug_state
);

  localparam int TW = 10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_DATA     = 4'd4,
    S_DATA_ACK = 4'd5,
    S_STOP     = 4'd6,
    S_DONE     = 4'd7
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            ack_err_q, ack_err_d;
  logic            busy_q, done_q;
  logic            scl_q, scl_d;
  logic            oe_q, oe_d;
  logic            sda_meta_q, sda_sync_q;
  logic            active, qtick, end_q1, end_q3;

  // Bus levels for a given state/quarter/bit: returns {scl, sda pull-down}.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q, logic b);
    logic [1:0] r;
    r = 2'b10;
    case (st)
      S_START:
        case (q)
          2'd2:    r = 2'b11;
          2'd3:    r = 2'b01;
          default: r = 2'b10;
        endcase
      S_ADDR, S_DATA:         r = {(q == 2'd1) || (q == 2'd2), !b};
      S_ADDR_ACK, S_DATA_ACK: r = {(q == 2'd1) || (q == 2'd2), 1'b0};
      S_STOP:
        case (q)
          2'd0:    r = 2'b01;
          2'd1:    r = 2'b11;
          default: r = 2'b10;
        endcase
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  assign active = state_q inside {S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP};
  assign qtick  = active && (tmr_q == TW'(CLK_DIV - 1));
  assign end_q1 = qtick && (qtr_q == 2'd1);
  assign end_q3 = qtick && (qtr_q == 2'd3);

  // Next-state, quarter timer, shift register and bus levels
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    if (active) begin
      tmr_d = qtick ? '0 : tmr_q + TW'(1);
      if (qtick) qtr_d = qtr_q + 2'd1;
    end
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        qtr_d = 2'd0;
        bit_d = 3'd0;
        if (cmd.cmd_valid && !busy_q) begin
          state_d   = S_START;
          sh_d      = {cmd.cmd_addr, 1'b0};
          data_d    = cmd.cmd_data;
          ack_err_d = 1'b0;
        end
      end
      S_START: if (end_q3) state_d = S_ADDR;
      S_ADDR, S_DATA: begin
        if (end_q3) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
        end
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        // SDA high in the middle of the ACK clock means nobody acknowledged
        if (end_q1 && sda_sync_q) ack_err_d = 1'b1;
        if (end_q3) begin
          if (state_q == S_ADDR_ACK && !ack_err_q) begin
            state_d = S_DATA;
            sh_d    = data_q;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: if (end_q3) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    {scl_d, oe_d} = bus_drive(state_d, qtr_d, sh_d[7]);
  end

  // State, datapath and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
      data_q     <= 8'd0;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      sda_meta_q <= 1'b0;
      sda_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      ack_err_q  <= ack_err_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  assign cmd.cmd_ready = !busy_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.ack_error = ack_err_q;
  assign scl           = scl_q;
  assign sda           = oe_q ? 1'b0 : 1'bz;
  assign debug_state   = state_q;

endmodule

// File: tb/tb_i2c_led_master.sv
// Directed bench for i2c_led_master with an I2C slave model and bus checker.
module tb_i2c_led_master;
  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl;
  logic [3:0] debug_state;
  logic       slv_drv = 1'b0;
  wire        sda;

  always #5 clk = ~clk;

  i2c_led_if bus ();

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  i2c_led_master #(.CLK_DIV(CD)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (bus),
    .scl         (scl),
    .sda         (sda),
    .debug_state (debug_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration
  logic [6:0] slv_addr     = 7'h55;
  logic       slv_data_ack = 1'b1;

  // Monitor / slave state (written only by the monitor process)
  int         ncyc = 0, bus_viol = 0, rise_cnt = 0, ncap = 0;
  logic [7:0] cap [0:63];
  logic       scl_p = 1'b1, sda_p = 1'b1, have_rise = 1'b0, have_fall = 1'b0;
  int         t_rise = 0, t_fall = 0;
  logic       s_active = 1'b0, s_match = 1'b0;
  int         s_bitn = 0, s_byte = 0;
  logic [7:0] s_sh = 8'd0;
  logic       scl_s, sda_s;

  // Bus rule checker and byte-capturing slave that ACKs slv_addr
  always @(negedge clk) begin
    ncyc++;
    scl_s = scl;
    sda_s = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (rst) begin
      have_rise = 1'b0; have_fall = 1'b0;
      s_active = 1'b0; slv_drv = 1'b0; s_bitn = 0;
    end else begin
      if (bus.done) begin have_rise = 1'b0; have_fall = 1'b0; end
      if (scl_p && scl_s && (sda_p != sda_s)) begin
        if (!((!sda_s && debug_state == 4'd1) || (sda_s && debug_state == 4'd6))) begin
          bus_viol++;
          $display("bus rule: SDA moved while SCL high at %0t (state %0d)", $time, debug_state);
        end
      end
      if (!scl_p && scl_s) begin
        rise_cnt++;
        if (have_fall && (ncyc - t_fall) != 2 * CD) begin
          bus_viol++;
          $display("bus rule: SCL low for %0d clocks at %0t", ncyc - t_fall, $time);
        end
        t_rise = ncyc; have_rise = 1'b1;
      end
      if (scl_p && !scl_s) begin
        if (have_rise && (ncyc - t_rise) != 2 * CD) begin
          bus_viol++;
          $display("bus rule: SCL high for %0d clocks at %0t", ncyc - t_rise, $time);
        end
        t_fall = ncyc; have_fall = 1'b1;
      end
      if (scl_p && scl_s && sda_p && !sda_s) begin
        s_active = 1'b1; s_bitn = 0; s_byte = 0; s_match = 1'b0;
      end else if (scl_p && scl_s && !sda_p && sda_s) begin
        s_active = 1'b0;
      end else if (s_active && !scl_p && scl_s) begin
        if (s_bitn < 8) s_sh = {s_sh[6:0], sda_s};
        s_bitn++;
      end else if (s_active && scl_p && !scl_s) begin
        if (s_bitn == 8) begin
          cap[6'(ncap)] = s_sh;
          ncap++;
          if (s_byte == 0) s_match = (s_sh[7:1] == slv_addr) && !s_sh[0];
          slv_drv = (s_byte == 0) ? s_match : (s_match && slv_data_ack);
        end else if (s_bitn == 9) begin
          slv_drv = 1'b0; s_bitn = 0; s_byte++;
        end
      end
    end
    scl_p = scl_s;
    sda_p = sda_s;
  end

  // Issue one command with the engine idle; dcyc is the clock period (1 = the
  // one right after the accept edge) in which done is seen high, -1 on timeout.
  task automatic run_cmd(input logic [6:0] a, input logic [7:0] d, output int dcyc,
                         output logic ack_at_done, output logic busy1, output logic ready1);
    @(posedge clk); #1;
    bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    dcyc = -1; ack_at_done = 1'bx; busy1 = 1'bx; ready1 = 1'bx;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (n == 1) begin busy1 = bus.busy; ready1 = bus.cmd_ready; end
      if (bus.done) begin dcyc = n; ack_at_done = bus.ack_error; break; end
    end
  endtask

  task automatic test_reset;
    logic sda_rd;
    rst = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 7'h55; bus.cmd_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_wins_busy: got %b want 0", bus.busy); end
    n_cmp++; if (debug_state !== 4'd0) begin n_bad++; $display("FAIL rst_wins_state: got %0d want 0", debug_state); end
    @(posedge clk); #1;
    rst = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    sda_rd = (sda === 1'b0) ? 1'b0 : 1'b1;
    n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL reset_scl: got %b want 1", scl); end
    n_cmp++; if (sda_rd !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want released", sda_rd); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.ack_error !== 1'b0) begin n_bad++; $display("FAIL reset_ack_error: got %b want 0", bus.ack_error); end
    n_cmp++; if (debug_state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", debug_state); end
  endtask

  task automatic test_write_ack;
    int dc, base, rb, vb; logic ak, b1, r1;
    base = ncap; rb = rise_cnt; vb = bus_viol; slv_data_ack = 1'b1;
    run_cmd(7'h55, 8'hA5, dc, ak, b1, r1);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL ack_busy_after_accept: got %b want 1", b1); end
    n_cmp++; if (r1 !== 1'b0) begin n_bad++; $display("FAIL ack_ready_after_accept: got %b want 0", r1); end
    n_cmp++; if (dc !== 321) begin n_bad++; $display("FAIL ack_done_cycle: got %0d want 321", dc); end
    n_cmp++; if (ak !== 1'b0) begin n_bad++; $display("FAIL ack_ack_error: got %b want 0", ak); end
    n_cmp++; if (ncap - base !== 2) begin n_bad++; $display("FAIL ack_byte_count: got %0d want 2", ncap - base); end
    n_cmp++; if (cap[6'(base)] !== 8'hAA) begin n_bad++; $display("FAIL ack_addr_byte: got %h want aa", cap[6'(base)]); end
    n_cmp++; if (cap[6'(base + 1)] !== 8'hA5) begin n_bad++; $display("FAIL ack_data_byte: got %h want a5", cap[6'(base + 1)]); end
    n_cmp++; if (rise_cnt - rb !== 19) begin n_bad++; $display("FAIL ack_scl_pulses: got %0d want 19", rise_cnt - rb); end
    n_cmp++; if (bus_viol - vb !== 0) begin n_bad++; $display("FAIL ack_bus_rules: got %0d violations want 0", bus_viol - vb); end
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ack_ready_after_done: got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ack_done_one_clock: got %b want 0", bus.done); end
    n_cmp++; if (bus.ack_error !== 1'b0) begin n_bad++; $display("FAIL ack_error_held: got %b want 0", bus.ack_error); end
  endtask

  task automatic test_addr_nack;
    int dc, base, rb, vb; logic ak, b1, r1;
    base = ncap; rb = rise_cnt; vb = bus_viol;
    run_cmd(7'h22, 8'h99, dc, ak, b1, r1);
    n_cmp++; if (dc !== 177) begin n_bad++; $display("FAIL anack_done_cycle: got %0d want 177", dc); end
    n_cmp++; if (ak !== 1'b1) begin n_bad++; $display("FAIL anack_ack_error: got %b want 1", ak); end
    n_cmp++; if (ncap - base !== 1) begin n_bad++; $display("FAIL anack_byte_count: got %0d want 1", ncap - base); end
    n_cmp++; if (cap[6'(base)] !== 8'h44) begin n_bad++; $display("FAIL anack_addr_byte: got %h want 44", cap[6'(base)]); end
    n_cmp++; if (rise_cnt - rb !== 10) begin n_bad++; $display("FAIL anack_scl_pulses: got %0d want 10", rise_cnt - rb); end
    n_cmp++; if (bus_viol - vb !== 0) begin n_bad++; $display("FAIL anack_bus_rules: got %0d violations want 0", bus_viol - vb); end
    @(negedge clk);
    n_cmp++; if (bus.ack_error !== 1'b1) begin n_bad++; $display("FAIL anack_error_held: got %b want 1", bus.ack_error); end
  endtask

  task automatic test_data_nack;
    int dc, base, rb, vb; logic ak, b1, r1;
    base = ncap; rb = rise_cnt; vb = bus_viol; slv_data_ack = 1'b0;
    run_cmd(7'h55, 8'h3C, dc, ak, b1, r1);
    slv_data_ack = 1'b1;
    n_cmp++; if (dc !== 321) begin n_bad++; $display("FAIL dnack_done_cycle: got %0d want 321", dc); end
    n_cmp++; if (ak !== 1'b1) begin n_bad++; $display("FAIL dnack_ack_error: got %b want 1", ak); end
    n_cmp++; if (cap[6'(base + 1)] !== 8'h3C) begin n_bad++; $display("FAIL dnack_data_byte: got %h want 3c", cap[6'(base + 1)]); end
    n_cmp++; if (rise_cnt - rb !== 19) begin n_bad++; $display("FAIL dnack_scl_pulses: got %0d want 19", rise_cnt - rb); end
    n_cmp++; if (bus_viol - vb !== 0) begin n_bad++; $display("FAIL dnack_bus_rules: got %0d violations want 0", bus_viol - vb); end
  endtask

  task automatic test_reset_mid;
    int dc, base, dones; logic ak, b1, r1, sda_rd;
    @(posedge clk); #1;
    bus.cmd_addr = 7'h55; bus.cmd_data = 8'hA5; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    // Quarter 30 spans edges 120..123 after the accept edge; reset lands on 122
    repeat (121) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sda_rd = (sda === 1'b0) ? 1'b0 : 1'b1;
    n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL midrst_scl: got %b want 1", scl); end
    n_cmp++; if (sda_rd !== 1'b1) begin n_bad++; $display("FAIL midrst_sda: got %b want released", sda_rd); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (debug_state !== 4'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", debug_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    base = ncap;
    run_cmd(7'h55, 8'h5A, dc, ak, b1, r1);
    n_cmp++; if (dc !== 321) begin n_bad++; $display("FAIL midrst_next_done: got %0d want 321", dc); end
    n_cmp++; if (ak !== 1'b0) begin n_bad++; $display("FAIL midrst_next_ack: got %b want 0", ak); end
    n_cmp++; if (cap[6'(base + 1)] !== 8'h5A) begin n_bad++; $display("FAIL midrst_next_data: got %h want 5a", cap[6'(base + 1)]); end
  endtask

  task automatic test_back_to_back;
    int acc0, acc1, nacc, e, dones, idles, base;
    logic fire;
    acc0 = -1; acc1 = -1; nacc = 0; e = 0; dones = 0; idles = 0; base = ncap;
    @(posedge clk); #1;
    bus.cmd_addr = 7'h55; bus.cmd_data = 8'h01; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && nacc < 2; i++) begin
      @(negedge clk);
      fire = bus.cmd_ready;
      if (bus.done) dones++;
      if (nacc == 1 && debug_state == 4'd0) idles++;
      @(posedge clk);
      e++;
      if (fire) begin
        if (nacc == 0) acc0 = e; else acc1 = e;
        nacc++;
        #1 bus.cmd_data = 8'h80;
        if (nacc == 2) bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin dones++; break; end
    end
    n_cmp++; if (nacc !== 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
    n_cmp++; if (acc1 - acc0 !== 322) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d want 322", acc1 - acc0); end
    n_cmp++; if (idles !== 1) begin n_bad++; $display("FAIL b2b_idle_clocks: got %0d want 1", idles); end
    n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d want 2", dones); end
    n_cmp++; if (ncap - base !== 4) begin n_bad++; $display("FAIL b2b_byte_count: got %0d want 4", ncap - base); end
    n_cmp++; if (cap[6'(base + 1)] !== 8'h01) begin n_bad++; $display("FAIL b2b_first_data: got %h want 01", cap[6'(base + 1)]); end
    n_cmp++; if (cap[6'(base + 3)] !== 8'h80) begin n_bad++; $display("FAIL b2b_second_data: got %h want 80", cap[6'(base + 3)]); end
    n_cmp++; if (bus.ack_error !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_error: got %b want 0", bus.ack_error); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 7'h00;
    bus.cmd_data  = 8'h00;
    test_reset();
    test_write_ack();
    test_addr_nack();
    test_data_nack();
    test_reset_mid();
    test_back_to_back();
    n_cmp++; if (bus_viol !== 0) begin n_bad++; $display("FAIL bus_rules_total: got %0d violations want 0", bus_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
